// File: rtl/nes_pitch_control.sv
// nes_pitch_control: debounced NES pad to pitch-shift controls (semitones with auto-repeat, fine, bypass).
module nes_pitch_control #(
    parameter int DEBOUNCE_CYCLES = 12500,
    parameter int REPEAT_DELAY    = 4000000,
    parameter int REPEAT_PERIOD   = 1250000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        buttons,
    output logic [7:0]        pressed,
    output logic signed [5:0] semitones,
    output logic signed [3:0] fine,
    output logic              bypass,
    output logic              changed
);
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic [7:0]  sync1, sync2, deb, deb_q;
    logic [15:0] db_cnt [8];
    state_t      state, state_nx;
    logic        dir, dir_nx, step, held, opp;
    logic [22:0] rcnt, rcnt_nx;
    logic signed [5:0] semi_nx;
    logic signed [3:0] fine_nx;
    logic        byp_nx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1  <= '0;
            sync2  <= '0;
            deb    <= '0;
            deb_q  <= '0;
            db_cnt <= '{default: '0};
        end else begin
            sync1 <= buttons;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 8; i++) begin
                if (sync2[i] == deb[i])
                    db_cnt[i] <= '0;
                else if (db_cnt[i] == 16'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else
                    db_cnt[i] <= db_cnt[i] + 16'd1;
            end
        end
    end

    // dir: 0 = Up, 1 = Down; the held direction and its opposite's fresh press end a repeat run
    assign held = dir ? deb[5] : deb[4];
    assign opp  = dir ? pressed[4] : pressed[5];

    always_comb begin
        state_nx = state;
        dir_nx   = dir;
        rcnt_nx  = rcnt + 23'd1;
        step     = 1'b0;
        if (pressed[3]) begin
            state_nx = IDLE;
            rcnt_nx  = '0;
        end else begin
            case (state)
                IDLE: begin
                    rcnt_nx = '0;
                    if (pressed[4] ^ pressed[5]) begin
                        state_nx = DELAY;
                        dir_nx   = pressed[5];
                        step     = 1'b1;
                    end
                end
                DELAY:
                    if (!held || opp) begin
                        state_nx = IDLE;
                        rcnt_nx  = '0;
                    end else if (rcnt == 23'(REPEAT_DELAY - 1)) begin
                        state_nx = REPEAT;
                        step     = 1'b1;
                        rcnt_nx  = '0;
                    end
                REPEAT:
                    if (!held || opp) begin
                        state_nx = IDLE;
                        rcnt_nx  = '0;
                    end else if (rcnt == 23'(REPEAT_PERIOD - 1)) begin
                        step    = 1'b1;
                        rcnt_nx = '0;
                    end
                default: begin
                    state_nx = IDLE;
                    rcnt_nx  = '0;
                end
            endcase
        end
    end

    always_comb begin
        semi_nx = semitones;
        fine_nx = fine;
        byp_nx  = bypass ^ pressed[2];
        if (step && !dir_nx && semitones != 6'sd12)
            semi_nx = semitones + 6'sd1;
        if (step && dir_nx && semitones != -6'sd12)
            semi_nx = semitones - 6'sd1;
        if (pressed[7] && !pressed[6] && fine != 4'sd7)
            fine_nx = fine + 4'sd1;
        if (pressed[6] && !pressed[7] && fine != -4'sd7)
            fine_nx = fine - 4'sd1;
        if (pressed[3]) begin
            semi_nx = '0;
            fine_nx = '0;
            byp_nx  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            dir       <= 1'b0;
            rcnt      <= '0;
            pressed   <= '0;
            semitones <= '0;
            fine      <= '0;
            bypass    <= 1'b0;
            changed   <= 1'b0;
        end else begin
            state     <= state_nx;
            dir       <= dir_nx;
            rcnt      <= rcnt_nx;
            pressed   <= deb & ~deb_q;
            semitones <= semi_nx;
            fine      <= fine_nx;
            bypass    <= byp_nx;
            changed   <= {semi_nx, fine_nx, byp_nx} != {semitones, fine, bypass};
        end
    end
endmodule
